// File: rtl/apb_bridge_ctrl_if.sv
// AHB-side request/response and APB3 bus signals of the bridge, grouped as one bundle.
// master: the bridge itself; slave: the AHB requester plus the APB peripherals.
interface apb_bridge_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 4
);
  logic              valid;
  logic              hwrite;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic [NSLV-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] hrdata;
  logic [1:0]        hresp;
  logic              hready_out;

  modport master (
    input  valid, hwrite, haddr, hwdata, prdata, pready, pslverr,
    output psel, penable, pwrite, paddr, pwdata, hrdata, hresp, hready_out
  );

  modport slave (
    output valid, hwrite, haddr, hwdata, prdata, pready, pslverr,
    input  psel, penable, pwrite, paddr, pwdata, hrdata, hresp, hready_out
  );
endinterface

// File: rtl/apb_bridge_ctrl.sv
// AHB-to-APB3 bridge controller: slot decode, PREADY wait states, PSLVERR and
// access timeout, two-cycle AHB ERROR response. All outputs are registered.
module apb_bridge_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NSLV     = 4,
  parameter int SLOT_LSB = 12,
  parameter int TIMEOUT  = 16
) (
  input logic               hclk,
  input logic               hresetn,
  apb_bridge_ctrl_if.master bus
);
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t         state;
  logic [SW-1:0]  slot_q;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  req_slot;
  logic           req_bad;

  assign req_slot = bus.haddr[SLOT_LSB +: SW];
  // Extra MSB keeps the range check meaningful when NSLV is a power of two.
  assign req_bad  = {1'b0, req_slot} >= (SW+1)'(NSLV);

  function automatic logic [NSLV-1:0] onehot(input logic [SW-1:0] s);
    return NSLV'(1) << s;
  endfunction

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state          <= IDLE;
      slot_q         <= '0;
      cnt            <= '0;
      bus.psel       <= '0;
      bus.penable    <= 1'b0;
      bus.pwrite     <= 1'b0;
      bus.paddr      <= '0;
      bus.pwdata     <= '0;
      bus.hrdata     <= '0;
      bus.hresp      <= 2'b00;
      bus.hready_out <= 1'b1;
    end else begin
      case (state)
        IDLE, ERR2: begin
          if (bus.valid) begin
            bus.paddr      <= bus.haddr;
            bus.pwrite     <= bus.hwrite;
            slot_q         <= req_slot;
            bus.penable    <= 1'b0;
            bus.hready_out <= 1'b0;
            if (req_bad) begin
              state     <= ERR1;
              bus.psel  <= '0;
              bus.hresp <= 2'b01;
            end else if (bus.hwrite) begin
              state     <= WWAIT;
              bus.psel  <= '0;
              bus.hresp <= 2'b00;
            end else begin
              state      <= SETUP;
              bus.psel   <= onehot(req_slot);
              bus.pwdata <= '0;
              bus.hresp  <= 2'b00;
            end
          end else begin
            state          <= IDLE;
            bus.hresp      <= 2'b00;
            bus.hready_out <= 1'b1;
          end
        end
        WWAIT: begin
          bus.pwdata <= bus.hwdata;
          bus.psel   <= onehot(slot_q);
          state      <= SETUP;
        end
        SETUP: begin
          bus.penable <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            bus.psel    <= '0;
            bus.penable <= 1'b0;
            if (bus.pslverr) begin
              state     <= ERR1;
              bus.hresp <= 2'b01;
            end else begin
              if (!bus.pwrite) bus.hrdata <= bus.prdata;
              state          <= IDLE;
              bus.hready_out <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (TIMEOUT != 0 && cnt == CNT_LAST) begin
              bus.psel    <= '0;
              bus.penable <= 1'b0;
              bus.hresp   <= 2'b01;
              state       <= ERR1;
            end
          end
        end
        ERR1: begin
          state          <= ERR2;
          bus.hready_out <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/apb_bridge_ctrl.md
# apb_bridge_ctrl

Parametrised AHB-to-APB bridge controller. It sits between the AHB slave interface (decoded `valid`, pipelined address/data) and an APB3 peripheral bus of NSLV slaves. It adds PREADY wait states, PSLVERR propagation, an APB access timeout and in-block slot decode, and returns a two-cycle AHB ERROR response on any failure.

## Interface
- `ADDR_W`, 32, address width (paddr, haddr)
- `DATA_W`, 32, data width (hwdata, pwdata, prdata, hrdata)
- `NSLV`, 4, number of APB slaves, 1..16
- `SLOT_LSB`, 12, LSB of slot index field in haddr; field width SW = max(1, clog2(NSLV))
- `TIMEOUT`, 16, maximum ACCESS cycles before abort; 0 disables the timeout
- `hclk`  in  1  clock; all state changes on rising edge
- `hresetn`  in  1  reset; one clock; reset is asynchronous and active-low
- `valid`  in  1  AHB transfer request (address phase)
- `hwrite`  in  1  direction of requested transfer
- `haddr`  in  ADDR_W  address phase address
- `hwdata`  in  DATA_W  write data, valid in cycle after acceptance
- `prdata`  in  DATA_W  APB read data
- `pready`  in  1  APB slave ready
- `pslverr`  in  1  APB slave error, sampled only with pready
- `psel`  out  NSLV  one-hot slave select
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `hrdata`  out  DATA_W  registered read data to AHB
- `hresp`  out  2  00 OKAY, 01 ERROR
- `hready_out`  out  1  AHB ready

## Operation
- States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2. All outputs come from registers or state decode only; no combinational path from `pready`, `pslverr` or `prdata` to AHB outputs.
- Accepting states: IDLE and ERR2 accept a request. `valid` is ignored in all other states.
  - On accept, latch haddr into paddr, latch hwrite into pwrite, and compute slot = haddr[SLOT_LSB +: SW].
  - slot >= NSLV: go to ERR1 with no APB access.
  - Otherwise, write goes to WWAIT; read goes to SETUP with pwdata cleared to 0.
- WWAIT: hready_out=0. Latch hwdata into pwdata, then go to SETUP.
- SETUP: psel[slot]=1, penable=0, hready_out=0. Go to ACCESS. Clear timeout counter.
- ACCESS: psel[slot]=1, penable=1, hready_out=0.
  - pready=1, pslverr=0: latch prdata into hrdata (reads only; writes leave hrdata unchanged), then go to IDLE.
  - pready=1, pslverr=1: go to ERR1. hrdata is unchanged.
  - pready=0: increment counter. If TIMEOUT!=0 and counter reaches TIMEOUT-1, go to ERR1.
- ERR1: hresp=01, hready_out=0, psel=0, penable=0. Go to ERR2.
- ERR2: hresp=01, hready_out=1. Accepts a request as IDLE does; otherwise go to IDLE.
- IDLE: hresp=00, hready_out=1, psel=0, penable=0.
- paddr, pwrite and pwdata hold their last values outside SETUP/ACCESS.

## Timing
- Reset values: all outputs 0 except hready_out=1. State IDLE, counter 0.
- Reset mid-transfer: psel and penable drop immediately (asynchronous), and no AHB response is produced.
- Write latency, accept edge E0 to hready_out=1 with zero wait states: E0 enters WWAIT, E1 SETUP, E2 ACCESS, E3 IDLE. hready_out is low for 3 cycles.
- Read latency: E0 enters SETUP, E1 ACCESS, E2 IDLE with hrdata valid. hready_out is low for 2 cycles.
- Each pready=0 cycle in ACCESS adds exactly one cycle.
- Timeout: ACCESS lasts at most TIMEOUT cycles, then ERR1.
- Error response: exactly 2 cycles with hresp=01, first with hready_out=0, second with hready_out=1.
- Back-to-back: a request presented in IDLE or ERR2 is accepted on that edge, so there are no bubble cycles beyond the latencies above.
- psel is one-hot or zero at all times. penable=1 only in ACCESS.

## Test plan
- Write to haddr=0x0000_2010 with hwdata=0xDEAD_BEEF and pready=1. Expect:
  - psel=0100 for 2 cycles
  - penable high 1 cycle
  - pwdata=0xDEAD_BEEF
  - hready_out low 3 cycles, hresp=00
- Read from slot 1 with pready low for 3 cycles and prdata=0x1234_5678. Expect:
  - ACCESS lasts 4 cycles
  - hrdata=0x1234_5678 when hready_out rises
  - hready_out low 5 cycles
- Read with pslverr=1 at pready. Expect:
  - hresp=01 for 2 cycles, with hready_out 0 then 1
  - hrdata unchanged
- With TIMEOUT=4 and pready stuck at 0. Expect:
  - ACCESS lasts exactly 4 cycles
  - then ERR1, with psel and penable dropping
  - then ERR2
  - then IDLE
- With NSLV=3, haddr slot=3. Expect psel stays 0, an immediate 2-cycle ERROR, and a new read accepted in ERR2 that completes normally.
- Assert hresetn low during ACCESS of a write. Expect:
  - all outputs at reset values asynchronously
  - after release, the next read completes with normal latency
